// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Arbitrates a single-port memory between the instruction-fetch port and the
// MEM-stage data port of a pipelined core. A single transaction is in flight at
// a time. Data requests win over fetch requests because the MEM-stage
// instruction is older. A BUSY phase that receives no mem_ack within
// TIMEOUT_CYC cycles is aborted: the owner still receives its ready pulse (with
// zero read data) so the pipeline never deadlocks, and the sticky err flag is
// raised.
//
// Parameters
//   TIMEOUT_CYC  BUSY cycles without mem_ack before abort (1..255)
//
// Ports
//   clk        clock, all state updates on the rising edge
//   reset      asynchronous active-low reset
//   if_req     fetch request, held with if_addr stable until if_ready
//   if_addr    fetch byte address
//   if_ready   one-cycle pulse: fetch complete, if_rdata valid
//   if_rdata   fetch data (zero when if_ready is low)
//   d_req      data request, held with operands stable until d_ready
//   d_we       1 = store, 0 = load
//   d_addr     data byte address
//   d_wdata    store data
//   d_ready    one-cycle pulse: data access complete
//   d_rdata    load data (zero when d_ready is low)
//   mem_req    request to the shared memory
//   mem_we     memory write enable
//   mem_addr   memory address (holds the last latched value while idle)
//   mem_wdata  memory write data (holds the last latched value while idle)
//   mem_rdata  memory read data, valid with mem_ack
//   mem_ack    one-cycle completion pulse from memory
//   stall      pipeline stall: a request is pending and not yet completing
//   err_clr    synchronous clear of err
//   err        sticky timeout flag
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall,
    input  logic        err_clr,
    output logic        err
);

    localparam logic [7:0] TIMEOUT_VAL = 8'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        D_BUSY  = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [7:0]  count_reg, count_next;
    logic        err_reg, err_next;
    logic        we_reg, we_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] wdata_reg, wdata_next;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            count_reg <= 8'd0;
            err_reg   <= 1'b0;
            we_reg    <= 1'b0;
            addr_reg  <= 32'd0;
            wdata_reg <= 32'd0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            err_reg   <= err_next;
            we_reg    <= we_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        err_next   = err_reg;
        we_next    = we_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;

        mem_req    = 1'b0;
        mem_we     = 1'b0;
        if_ready   = 1'b0;
        if_rdata   = 32'd0;
        d_ready    = 1'b0;
        d_rdata    = 32'd0;

        // A timeout later in this block overrides the clear, so a
        // simultaneous clear and timeout leaves err set.
        if (err_clr) begin
            err_next = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                // Counter is zeroed here so every BUSY phase starts from 0.
                count_next = 8'd0;
                if (d_req) begin
                    we_next    = d_we;
                    addr_next  = d_addr;
                    wdata_next = d_wdata;
                    state_next = D_BUSY;
                end else if (if_req) begin
                    // Fetches never write; wdata keeps its last value.
                    we_next    = 1'b0;
                    addr_next  = if_addr;
                    state_next = IF_BUSY;
                end
            end

            IF_BUSY, D_BUSY: begin
                mem_req = 1'b1;
                mem_we  = we_reg;
                if (mem_ack) begin
                    // Completion takes priority over a timeout in the same cycle.
                    if (state_reg == D_BUSY) begin
                        d_ready = 1'b1;
                        d_rdata = mem_rdata;
                    end else begin
                        if_ready = 1'b1;
                        if_rdata = mem_rdata;
                    end
                    state_next = IDLE;
                end else if (count_reg >= TIMEOUT_VAL) begin
                    // Counter has reached the limit: release the requester
                    // with zero data instead of waiting forever.
                    if (state_reg == D_BUSY) begin
                        d_ready = 1'b1;
                    end else begin
                        if_ready = 1'b1;
                    end
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else begin
                    count_next = count_reg + 8'd1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign err       = err_reg;
    assign stall     = (if_req & ~if_ready) | (d_req & ~d_ready);

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall;
    logic        err_clr;
    logic        err;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT_CYC(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ready  (if_ready),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ready   (d_ready),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .stall     (stall),
        .err_clr   (err_clr),
        .err       (err)
    );

    // Scoreboard entry: which port must complete next and with what data.
    typedef struct {
        bit          is_d;
        logic [31:0] rdata;
    } sb_t;

    // Table vector: one complete transaction from request to ready.
    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ack_delay;   // BUSY cycles without ack before the ack cycle
        logic [31:0] mem_rdata;
        bit          drop_req;    // requester lets go in the first BUSY cycle
        bit          clr_in_busy; // err_clr held high throughout BUSY
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    sb_t  sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_exp(input bit is_d, input logic [31:0] rdata);
        sb_t e;
        e.is_d  = is_d;
        e.rdata = rdata;
        sb_q.push_back(e);
    endtask

    task automatic ready_seen(input bit is_d, input logic [31:0] rd, input logic [31:0] other);
        sb_t e;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_ready: got %s ready=1 required ready=0 (nothing outstanding)",
                     is_d ? "d" : "if");
        end else begin
            e = sb_q.pop_front();
            check("ready_owner_is_d", 32'(is_d), 32'(e.is_d));
            check("ready_rdata", rd, e.rdata);
            check("other_rdata_zero", other, 32'h0);
            $display("txn done: %s rdata=0x%08h expected=0x%08h", is_d ? "data " : "fetch", rd, e.rdata);
        end
    endtask

    // Completion monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            if (d_ready)  ready_seen(1'b1, d_rdata, if_rdata);
            if (if_ready) ready_seen(1'b0, if_rdata, d_rdata);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time exceeded limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        vec_t v;
        int   done_c;
        int   done_at;
        bit   done;

        //            is_d we addr          wdata          dly mem_rdata      drop clr exp_rdata     err
        vecs[0] = '{1'b0, 1'b0, 32'h100, 32'h0,          2, 32'h00500093, 1'b0, 1'b0, 32'h00500093, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 32'h040, 32'h0,          1, 32'hCAFEF00D, 1'b1, 1'b0, 32'hCAFEF00D, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 32'h020, 32'hDEADBEEF,   0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0};
        vecs[3] = '{1'b1, 1'b0, 32'h044, 32'h0,          4, 32'h00001234, 1'b0, 1'b0, 32'h00001234, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 32'h048, 32'h0,          9, 32'h77777777, 1'b0, 1'b0, 32'h0,        1'b1};
        vecs[5] = '{1'b0, 1'b0, 32'h104, 32'h0,          3, 32'h00000013, 1'b0, 1'b1, 32'h00000013, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 32'h108, 32'h0,          9, 32'h00000099, 1'b0, 1'b1, 32'h0,        1'b1};

        reset     = 1'b0;
        if_req    = 1'b0;
        if_addr   = 32'h0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = 32'h0;
        d_wdata   = 32'h0;
        mem_rdata = 32'h0;
        mem_ack   = 1'b0;
        err_clr   = 1'b0;

        // Reset state
        #3;
        check("rst_mem_req",   32'(mem_req),  32'd0);
        check("rst_mem_we",    32'(mem_we),   32'd0);
        check("rst_if_ready",  32'(if_ready), 32'd0);
        check("rst_d_ready",   32'(d_ready),  32'd0);
        check("rst_err",       32'(err),      32'd0);
        check("rst_mem_addr",  mem_addr,      32'h0);
        check("rst_mem_wdata", mem_wdata,     32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Table-driven single transactions
        for (int i = 0; i < 7; i++) begin
            v       = vecs[i];
            done_c  = (v.ack_delay < TO) ? v.ack_delay : TO;
            done    = 1'b0;
            done_at = -1;
            if (v.is_d) begin
                d_req   = 1'b1;
                d_we    = v.we;
                d_addr  = v.addr;
                d_wdata = v.wdata;
            end else begin
                if_req  = 1'b1;
                if_addr = v.addr;
            end
            push_exp(v.is_d, v.exp_rdata);
            @(posedge clk); #1;
            for (int c = 0; c <= 30 && !done; c++) begin
                check("busy_mem_req",  32'(mem_req), 32'd1);
                check("busy_mem_we",   32'(mem_we),  32'(v.we));
                check("busy_mem_addr", mem_addr,     v.addr);
                if (v.is_d && v.we) check("busy_mem_wdata", mem_wdata, v.wdata);
                if (v.clr_in_busy) err_clr = 1'b1;
                if (c == 0 && v.drop_req) begin
                    d_req  = 1'b0;
                    if_req = 1'b0;
                end
                mem_rdata = v.mem_rdata;
                mem_ack   = (c == v.ack_delay);
                @(negedge clk);
                check("busy_stall", 32'(stall), (v.drop_req || c == done_c) ? 32'd0 : 32'd1);
                if (d_ready | if_ready) begin
                    done    = 1'b1;
                    done_at = c;
                end
                @(posedge clk); #1;
            end
            mem_ack   = 1'b0;
            mem_rdata = 32'h0;
            err_clr   = 1'b0;
            d_req     = 1'b0;
            if_req    = 1'b0;
            check("done_cycle",   32'(done_at),         32'(done_c));
            check("post_mem_req", 32'(mem_req),         32'd0);
            check("post_mem_we",  32'(mem_we),          32'd0);
            check("post_ready",   32'(if_ready | d_ready), 32'd0);
            check("post_hold_addr", mem_addr,           v.addr);
            check("post_err",     32'(err),             32'(v.exp_err));
        end

        // Plain err_clr pulse clears the sticky flag
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        check("err_clr", 32'(err), 32'd0);

        // Simultaneous store and fetch: store first, one idle cycle, then fetch
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h20;
        d_wdata = 32'hDEADBEEF;
        if_req  = 1'b1;
        if_addr = 32'h200;
        push_exp(1'b1, 32'h0);
        push_exp(1'b0, 32'hAAAA5555);
        @(posedge clk); #1;
        check("arb_d_mem_we",    32'(mem_we), 32'd1);
        check("arb_d_mem_addr",  mem_addr,    32'h20);
        check("arb_d_mem_wdata", mem_wdata,   32'hDEADBEEF);
        mem_ack   = 1'b1;
        mem_rdata = 32'h0;
        @(negedge clk);
        check("arb_d_ready", 32'(d_ready), 32'd1);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        d_req   = 1'b0;
        check("arb_idle_mem_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        check("arb_idle_stall", 32'(stall), 32'd1);
        @(posedge clk); #1;
        check("arb_if_mem_req",  32'(mem_req), 32'd1);
        check("arb_if_mem_we",   32'(mem_we),  32'd0);
        check("arb_if_mem_addr", mem_addr,     32'h200);
        mem_ack   = 1'b1;
        mem_rdata = 32'hAAAA5555;
        @(negedge clk);
        check("arb_if_ready", 32'(if_ready), 32'd1);
        @(posedge clk); #1;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        if_req    = 1'b0;

        // Back-to-back loads with a same-cycle ack starve the fetch port
        d_req     = 1'b1;
        d_we      = 1'b0;
        d_addr    = 32'h80;
        if_req    = 1'b1;
        if_addr   = 32'h400;
        mem_rdata = 32'h0BADF00D;
        repeat (4) push_exp(1'b1, 32'h0BADF00D);
        for (int c = 0; c < 8; c++) begin
            mem_ack = mem_req;
            @(negedge clk);
            check("b2b_d_ready",  32'(d_ready),  32'(c % 2 == 1));
            check("b2b_if_ready", 32'(if_ready), 32'd0);
            check("b2b_stall",    32'(stall),    32'd1);
            @(posedge clk); #1;
        end
        d_req     = 1'b0;
        if_req    = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        @(posedge clk); #1;

        // Reset one cycle into a fetch: asynchronous drop, late ack ignored
        if_req  = 1'b1;
        if_addr = 32'h300;
        @(posedge clk); #1;
        check("rst_mid_pre_mem_req", 32'(mem_req), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_mem_req",  32'(mem_req),  32'd0);
        check("rst_mid_mem_addr", mem_addr,      32'h0);
        check("rst_mid_stall",    32'(stall),    32'd1);
        @(posedge clk); #1;
        check("rst_mid_if_ready", 32'(if_ready), 32'd0);
        reset     = 1'b1;
        if_req    = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h0000FFFF;
        @(negedge clk);
        check("late_ack_if_ready", 32'(if_ready), 32'd0);
        check("late_ack_if_rdata", if_rdata,      32'h0);
        check("late_ack_stall",    32'(stall),    32'd0);
        @(posedge clk); #1;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        check("late_ack_mem_req", 32'(mem_req), 32'd0);

        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
